// File: rtl/mgmt_rx_frame_buffer_if.sv
// Port bundle for mgmt_rx_frame_buffer: frame write side, data peek/pop side,
// header (frame length) side and drop statistics.
interface mgmt_rx_frame_buffer_if;
  logic        wr_start;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [2:0]  wr_bytes;
  logic        wr_commit;
  logic        wr_drop;
  logic        rd_en;
  logic        rd_pop_single;
  logic [31:0] rd_data;
  logic        header_rd_en;
  logic        header_rd_empty;
  logic [10:0] header_rd_data;
  logic [15:0] drop_count;

  modport master (
    output wr_start, wr_en, wr_data, wr_bytes, wr_commit, wr_drop,
    output rd_en, rd_pop_single, header_rd_en,
    input  rd_data, header_rd_empty, header_rd_data, drop_count
  );

  modport slave (
    input  wr_start, wr_en, wr_data, wr_bytes, wr_commit, wr_drop,
    input  rd_en, rd_pop_single, header_rd_en,
    output rd_data, header_rd_empty, header_rd_data, drop_count
  );
endinterface

// File: rtl/mgmt_rx_frame_buffer.sv
// Frame-granular RX buffer: words are held speculatively until commit, then published
// atomically to the data FIFO plus a length entry in the header FIFO.
// Define MGMT_RXBUF_STATS_EN to enable the drop_count statistics counter.
module mgmt_rx_frame_buffer #(
  parameter int DATA_DEPTH   = 1024,
  parameter int HEADER_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mgmt_rx_frame_buffer_if.slave  bus
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int HW = $clog2(HEADER_DEPTH);
  localparam logic [AW:0] DWRAP = {1'b1, {AW{1'b0}}};
  localparam logic [HW:0] HWRAP = {1'b1, {HW{1'b0}}};

  typedef enum logic {FR_OK = 1'b0, FR_BAD = 1'b1} frame_e;

  frame_e       fr_q, fr_d, fr_base;
  logic [AW:0]  wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]  wp_base;
  logic [11:0]  cnt_q, cnt_d, cnt_base, cnt_sum;
  logic         data_full, len_over, frame_ok;
  logic         mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]  mem [DATA_DEPTH];
  logic [31:0]  rd_data_q;

  logic [10:0]  hmem [HEADER_DEPTH];
  logic [HW:0]  hwr_ptr_q, hwr_ptr_d, hrd_ptr_q, hrd_ptr_d;
  logic         hdr_push, hdr_pop, hdr_full, hdr_empty;
  logic [10:0]  hdr_wdata;
  logic         drop_inc;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A start in this cycle rewinds the frame before the same-cycle word is considered.
  always_comb begin
    wp_base  = wr_ptr_q;
    cnt_base = cnt_q;
    fr_base  = fr_q;
    if (bus.wr_start) begin
      wp_base  = commit_ptr_q;
      cnt_base = '0;
      fr_base  = FR_OK;
    end
  end

  assign data_full = (wp_base ^ rd_ptr_q) == DWRAP;
  assign cnt_sum   = cnt_base + 12'(bus.wr_bytes);
  assign len_over  = cnt_sum > 12'd2047;
  assign mem_waddr = wp_base[AW-1:0];

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_q         <= FR_OK;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      cnt_q        <= '0;
    end else begin
      fr_q         <= fr_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Frame next-state: word first, then end-of-frame (drop beats commit)
  always_comb begin
    fr_d         = fr_base;
    wr_ptr_d     = wp_base;
    cnt_d        = cnt_base;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    hdr_push     = 1'b0;
    hdr_wdata    = '0;
    drop_inc     = 1'b0;
    if (bus.wr_en) begin
      if (data_full || len_over) begin
        fr_d = FR_BAD;
      end else if (frame_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wp_base + (AW+1)'(1);
        cnt_d    = cnt_sum;
      end
    end
    if (bus.wr_drop) begin
      wr_ptr_d = commit_ptr_q;
      cnt_d    = '0;
      fr_d     = FR_OK;
    end else if (bus.wr_commit) begin
      if (fr_d == FR_OK && cnt_d != 12'd0 && !hdr_full) begin
        commit_ptr_d = wr_ptr_d;
        hdr_push     = 1'b1;
        hdr_wdata    = cnt_d[10:0];
      end else begin
        wr_ptr_d = commit_ptr_q;
        drop_inc = (fr_d == FR_BAD) || (cnt_d != 12'd0);
      end
      cnt_d = '0;
      fr_d  = FR_OK;
    end
  end

  // Frame state output decode
  always_comb begin
    frame_ok = (fr_base == FR_OK);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.wr_data;
  end

  assign rd_ptr_d = (bus.rd_pop_single && rd_ptr_q != commit_ptr_q) ?
                    rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (bus.rd_en) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  assign bus.rd_data = rd_data_q;

  assign hdr_empty = (hwr_ptr_q == hrd_ptr_q);
  assign hdr_full  = (hwr_ptr_q ^ hrd_ptr_q) == HWRAP;
  assign hdr_pop   = bus.header_rd_en && !hdr_empty;
  assign hwr_ptr_d = hdr_push ? hwr_ptr_q + (HW+1)'(1) : hwr_ptr_q;
  assign hrd_ptr_d = hdr_pop  ? hrd_ptr_q + (HW+1)'(1) : hrd_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hwr_ptr_q <= '0;
      hrd_ptr_q <= '0;
    end else begin
      hwr_ptr_q <= hwr_ptr_d;
      hrd_ptr_q <= hrd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_push) hmem[hwr_ptr_q[HW-1:0]] <= hdr_wdata;
  end

  // Empty shows zero so the length output has a defined reset value.
  assign bus.header_rd_empty = hdr_empty;
  assign bus.header_rd_data  = hdr_empty ? 11'd0 : hmem[hrd_ptr_q[HW-1:0]];

`ifdef MGMT_RXBUF_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst)           drop_q <= '0;
    else if (drop_inc) drop_q <= sat_inc16(drop_q);
  end

  assign bus.drop_count = drop_q;
`else
  logic unused_drop_inc;
  logic [15:0] unused_sat;
  assign unused_drop_inc = drop_inc;
  assign unused_sat      = sat_inc16(16'd0);
  assign bus.drop_count  = 16'd0;
`endif
endmodule
